cmp_result_monitor: RTL
=======================

# cmp_result_monitor

Downstream stage of the 6-bit comparator. It pipelines an operand-valid strobe so that it lines up with the comparator's registered E/L/G outputs. It classifies each valid result, keeps saturating per-outcome counts, and flags illegal (non-one-hot) results. It also detects runs of identical outcomes, giving test and debug logic a cycle-accurate summary of comparator activity.

## Interface
- CNT_W, 8, width of each outcome counter (saturating)
- STREAK_N, 4, run length of identical outcomes that asserts STREAK (2..15)
- LAT, 2, comparator latency in cycles from operand capture to registered E/L/G
- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  reset; asynchronous, active-low; clears all state immediately
- VLD  in  1  high in the cycle A/B/S are presented to the comparator inputs
- CLR  in  1  synchronous clear of counters, flags and run state
- E  in  1  comparator registered equal output
- L  in  1  comparator registered less-than output
- G  in  1  comparator registered greater-than output
- CNT_E  out  CNT_W  number of valid E results
- CNT_L  out  CNT_W  number of valid L results
- CNT_G  out  CNT_W  number of valid G results
- LAST  out  2  code of the last legal result: 00 none, 01 L, 10 E, 11 G
- RES_VLD  out  1  one-cycle pulse: a legal result was absorbed on the previous edge
- STREAK  out  1  high while the current run of identical legal codes is at least STREAK_N
- ERR  out  1  sticky; an illegal E/L/G pattern was sampled while valid

## Operation
- Valid pipeline: a LAT-deep shift register vp[LAT-1:0] takes VLD at vp[0]. vp[LAT-1] qualifies E/L/G sampling.
- Legal pattern: exactly one of E, L, G is high. Code map: L→01, E→10, G→11.
- Sample cycle (vp[LAT-1]=1, legal):
  - Increment the matching counter; it saturates at 2^CNT_W−1 and never wraps.
  - LAST takes the code, and RES_VLD pulses next cycle.
  - Run counter: if the code equals LAST and LAST≠00, increment; otherwise load 1. It saturates at STREAK_N.
  - STREAK is high when the run counter equals STREAK_N.
- Sample cycle (vp[LAT-1]=1, illegal: zero or more than one of E/L/G high):
  - ERR is set.
  - Counters and LAST are unchanged.
  - Run counter clears to 0 and STREAK drops; RES_VLD stays low.
- Cycles with vp[LAT-1]=0:
  - No state change except the pipeline shift.
  - E/L/G are ignored, and the streak is not broken.
- CLR (synchronous):
  - Zeroes counters, LAST, run counter, STREAK, ERR and RES_VLD.
  - The valid pipeline keeps shifting, so operands already in flight are still sampled after CLR.
  - If CLR coincides with a sample cycle, CLR wins and that sample is discarded.
- Each counter is independent; saturation of one does not affect the others.

## Timing
- RST low, asynchronous: vp, counters, LAST, run counter, STREAK, ERR and RES_VLD are all 0. Mid-operation RST discards in-flight valids.
- VLD high at edge k (same edge the comparator captures A/B/S):
  - Result is sampled at edge k+LAT.
  - Counters, LAST, STREAK and ERR are visible after edge k+LAT.
  - RES_VLD is high from edge k+LAT to edge k+LAT+1.
- Back-to-back VLD on every cycle gives one sample per cycle with no bubbles.
- All outputs are registered; there is no combinational path from any input to any output.
- Run counter width is 4 bits.

## Test plan
- Reset then idle:
  - RST low 2 cycles, then high; E=L=G=0 with VLD=0 for 10 cycles.
  - Required: all outputs remain 0 and ERR=0.
- Latency check:
  - VLD=1 one cycle with A=B=2, S=0.
  - Required: after edge k+2, CNT_E=1, LAST=10 and RES_VLD is a single pulse; CNT_L=CNT_G=0.
- Streak:
  - 4 consecutive valid G results (A=62, B=60, S=1), then one L.
  - Required: STREAK rises after the 4th sample. After the L it falls, LAST=01 and CNT_G=4.
- Illegal pattern:
  - Force E=L=1 on a sample cycle.
  - Required: ERR=1 and stays set; counters unchanged; STREAK=0.
  - Then CLR for 1 cycle: ERR=0 and all counters are 0.
- Saturation:
  - 260 consecutive valid E results with CNT_W=8.
  - Required: CNT_E holds 255 with no wrap; CNT_L and CNT_G stay 0.
- CLR vs in-flight operand:
  - VLD at edge k, CLR at edge k+2.
  - Required: the sample is discarded, counters are 0, RES_VLD stays low.
  - VLD at edge k with CLR at edge k+1: the sample is counted at k+2.

Source files
------------

// File: rtl/cmp_result_monitor.sv
// Result monitor for the 6-bit comparator: aligns operand-valid with the registered E/L/G,
// counts legal outcomes, tracks runs of identical codes and flags non-one-hot results.
module cmp_result_monitor #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned STREAK_N = 4,
  parameter int unsigned LAT      = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VLD,
  input  logic             CLR,
  input  logic             E,
  input  logic             L,
  input  logic             G,
  output logic [CNT_W-1:0] CNT_E,
  output logic [CNT_W-1:0] CNT_L,
  output logic [CNT_W-1:0] CNT_G,
  output logic [1:0]       LAST,
  output logic             RES_VLD,
  output logic             STREAK,
  output logic             ERR
);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [3:0]       StreakN = 4'(STREAK_N);

  logic [LAT-1:0]   vp_q, vp_d;
  logic [CNT_W-1:0] cnt_e_q, cnt_e_d;
  logic [CNT_W-1:0] cnt_l_q, cnt_l_d;
  logic [CNT_W-1:0] cnt_g_q, cnt_g_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       run_q, run_d;
  logic             streak_q, streak_d;
  logic             err_q, err_d;
  logic             res_vld_q, res_vld_d;

  logic             sample;
  logic             legal;
  logic [1:0]       code;

  always_comb begin
    legal = 1'b1;
    code  = 2'b00;
    case ({E, L, G})
      3'b100:  code = 2'b10;
      3'b010:  code = 2'b01;
      3'b001:  code = 2'b11;
      default: legal = 1'b0;
    endcase
  end

  assign sample = vp_q[LAT-1];

  always_comb begin
    vp_d[0] = VLD;
    for (int unsigned i = 1; i < LAT; i++) begin
      vp_d[i] = vp_q[i-1];
    end

    cnt_e_d   = cnt_e_q;
    cnt_l_d   = cnt_l_q;
    cnt_g_d   = cnt_g_q;
    last_d    = last_q;
    run_d     = run_q;
    streak_d  = streak_q;
    err_d     = err_q;
    res_vld_d = 1'b0;

    if (CLR) begin
      // The valid pipeline is deliberately left shifting so in-flight operands survive CLR.
      cnt_e_d  = '0;
      cnt_l_d  = '0;
      cnt_g_d  = '0;
      last_d   = 2'b00;
      run_d    = 4'd0;
      streak_d = 1'b0;
      err_d    = 1'b0;
    end else if (sample) begin
      if (legal) begin
        unique case (code)
          2'b10:   cnt_e_d = (cnt_e_q == CntMax) ? cnt_e_q : cnt_e_q + CNT_W'(1);
          2'b01:   cnt_l_d = (cnt_l_q == CntMax) ? cnt_l_q : cnt_l_q + CNT_W'(1);
          default: cnt_g_d = (cnt_g_q == CntMax) ? cnt_g_q : cnt_g_q + CNT_W'(1);
        endcase
        if ((code == last_q) && (last_q != 2'b00)) begin
          run_d = (run_q == StreakN) ? run_q : run_q + 4'd1;
        end else begin
          run_d = 4'd1;
        end
        last_d    = code;
        streak_d  = (run_d == StreakN);
        res_vld_d = 1'b1;
      end else begin
        err_d    = 1'b1;
        run_d    = 4'd0;
        streak_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vp_q      <= '0;
      cnt_e_q   <= '0;
      cnt_l_q   <= '0;
      cnt_g_q   <= '0;
      last_q    <= 2'b00;
      run_q     <= 4'd0;
      streak_q  <= 1'b0;
      err_q     <= 1'b0;
      res_vld_q <= 1'b0;
    end else begin
      vp_q      <= vp_d;
      cnt_e_q   <= cnt_e_d;
      cnt_l_q   <= cnt_l_d;
      cnt_g_q   <= cnt_g_d;
      last_q    <= last_d;
      run_q     <= run_d;
      streak_q  <= streak_d;
      err_q     <= err_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign CNT_E   = cnt_e_q;
  assign CNT_L   = cnt_l_q;
  assign CNT_G   = cnt_g_q;
  assign LAST    = last_q;
  assign RES_VLD = res_vld_q;
  assign STREAK  = streak_q;
  assign ERR     = err_q;

endmodule
